// File: rtl/spi_pixel_loader.sv
// SPI mode-0 slave that streams MSB-first pixel bytes into the image SRAM write port,
// holding a completed frame until the consumer acknowledges it.
module spi_pixel_loader #(
  parameter int unsigned IMAGE_SIZE       = 65536,
  parameter int unsigned IMAGE_ADDR_WIDTH = 16,
  parameter int unsigned RGB_SIZE         = 8,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        SPI_CLK,
  input  logic                        SPI_MOSI,
  input  logic                        SPI_CS,
  input  logic                        frame_ack,
  output logic                        ram_we,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_addr,
  output logic [RGB_SIZE-1:0]         ram_data,
  output logic                        frame_ready,
  output logic                        request_flag,
  output logic                        overrun
);

  localparam int unsigned CntW = (RGB_SIZE > 2) ? $clog2(RGB_SIZE) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(RGB_SIZE - 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LastAddr = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  typedef enum logic [0:0] {StLoad, StFull} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0]      sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                        sclk_hist_q;
  logic [RGB_SIZE-2:0]         shift_q;
  logic [CntW-1:0]             bit_cnt_q;
  logic [IMAGE_ADDR_WIDTH-1:0] addr_q;
  logic [RGB_SIZE-1:0]         data_q;
  logic                        we_q;
  logic                        overrun_q;

  logic                        sync_clk, sync_mosi, sync_cs;
  logic                        sclk_rise, byte_done;
  logic [RGB_SIZE-1:0]         next_byte;

  assign sync_clk  = sclk_sync_q[SYNC_STAGES-1];
  assign sync_mosi = mosi_sync_q[SYNC_STAGES-1];
  assign sync_cs   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sync_clk & ~sclk_hist_q;
  assign byte_done = sclk_rise & ~sync_cs & (bit_cnt_q == LastBit);
  assign next_byte = {shift_q, sync_mosi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_hist_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
      sclk_hist_q <= sync_clk;
      we_q        <= 1'b0;

      // Deselect drops any partial byte; stored bytes and the address survive.
      if (sync_cs) begin
        bit_cnt_q <= '0;
      end else if (sclk_rise) begin
        shift_q   <= next_byte[RGB_SIZE-2:0];
        bit_cnt_q <= byte_done ? '0 : bit_cnt_q + CntW'(1);
      end

      if (byte_done) begin
        if (state_q == StLoad) begin
          we_q   <= 1'b1;
          data_q <= next_byte;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      // Address advances as the write pulse ends, so it is stable while ram_we is high.
      if (we_q) begin
        addr_q <= (addr_q == LastAddr) ? '0 : addr_q + IMAGE_ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: if (we_q && (addr_q == LastAddr)) state_d = StFull;
      StFull: if (frame_ack) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  assign ram_we       = we_q;
  assign ram_addr     = addr_q;
  assign ram_data     = data_q;
  assign frame_ready  = (state_q == StFull);
  assign request_flag = (state_q == StLoad);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Randomized bench for spi_pixel_loader: a frame-level model predicts every SRAM write and
// the ready/request/overrun flags, with literal checks pinning the directed scenarios.
module tb_spi_pixel_loader;

  localparam int unsigned Size  = 16;
  localparam int unsigned AddrW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             SPI_CLK = 1'b0;
  logic             SPI_MOSI = 1'b0;
  logic             SPI_CS = 1'b1;
  logic             frame_ack = 1'b0;
  logic             ram_we;
  logic [AddrW-1:0] ram_addr;
  logic [7:0]       ram_data;
  logic             frame_ready;
  logic             request_flag;
  logic             overrun;

  spi_pixel_loader #(
    .IMAGE_SIZE      (Size),
    .IMAGE_ADDR_WIDTH(AddrW),
    .RGB_SIZE        (8),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .SPI_CLK     (SPI_CLK),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_CS      (SPI_CS),
    .frame_ack   (frame_ack),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .frame_ready (frame_ready),
    .request_flag(request_flag),
    .overrun     (overrun)
  );

  always #10 clk = ~clk;

  // Behavioural model of the frame buffer
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [11:0] exp_q[$];
  bit          model_full = 0;
  bit          model_ovr  = 0;
  int unsigned model_addr = 0;
  bit          settled    = 0;
  int unsigned we_count   = 0;
  logic [AddrW-1:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int unsigned half = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("write_addr", 32'(ram_addr), 32'(e[11:8]));
          check("write_data", 32'(ram_data), 32'(e[7:0]));
        end
        we_count++;
        last_addr = ram_addr;
        last_data = ram_data;
      end
      if (settled) begin
        check("frame_ready", 32'(frame_ready), 32'(model_full));
        check("request_flag", 32'(request_flag), 32'(!model_full));
        check("overrun", 32'(overrun), 32'(model_ovr));
        check("addr_hold", 32'(ram_addr), model_addr);
        check("we_idle", 32'(ram_we), 0);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic settle();
    wait_clks(4);
    settled = 1;
  endtask

  task automatic accept_byte(input logic [7:0] b);
    if (!model_full) begin
      exp_q.push_back({4'(model_addr), b});
      model_addr++;
      if (model_addr == Size) begin
        model_full = 1;
        model_addr = 0;
      end
    end else begin
      model_ovr = 1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit collide);
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = b[7-i];
      wait_clks(half);
      SPI_CLK = 1'b1;
      if (collide && i == nbits - 1) begin
        // Land the ack on the same edge that sees the completed byte.
        fork
          begin
            repeat (2) @(posedge clk);
            #1 frame_ack = 1'b1;
            @(posedge clk);
            #1 frame_ack = 1'b0;
          end
          wait_clks(half);
        join
      end else begin
        wait_clks(half);
      end
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic send_txn(input logic [7:0] bytes[$]);
    settled = 0;
    SPI_CS = 1'b0;
    wait_clks(half);
    foreach (bytes[k]) begin
      accept_byte(bytes[k]);
      send_bits(bytes[k], 8, 0);
    end
    SPI_CS = 1'b1;
    wait_clks(half);
    settle();
  endtask

  task automatic send_one(input logic [7:0] b);
    logic [7:0] q[$];
    q.push_back(b);
    send_txn(q);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    settled = 0;
    SPI_CS = 1'b0;
    wait_clks(half);
    send_bits(b, nbits, 0);
    SPI_CS = 1'b1;
    wait_clks(half);
    settle();
  endtask

  task automatic pulse_ack();
    settled = 0;
    @(posedge clk);
    #1 frame_ack = 1'b1;
    @(posedge clk);
    #1 frame_ack = 1'b0;
    model_full = 0;
    settle();
  endtask

  task automatic do_reset();
    settled = 0;
    SPI_CLK = 1'b0;
    SPI_CS = 1'b1;
    #3 rst = 1'b1;
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
    model_full = 0;
    model_ovr  = 0;
    model_addr = 0;
    we_count   = 0;
    #1;
    check("rst_we", 32'(ram_we), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_data", 32'(ram_data), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_request", 32'(request_flag), 1);
    check("rst_overrun", 32'(overrun), 0);
    wait_clks(2);
    rst = 1'b0;
    wait_clks(3);
    settle();
  endtask

  initial begin
    logic [7:0] q[$];
    int unsigned sent;

    do_reset();

    // Single byte
    send_one(8'hA5);
    check("single_count", we_count, 1);
    check("single_addr", 32'(last_addr), 0);
    check("single_data", 32'(last_data), 32'hA5);
    check("single_request", 32'(request_flag), 1);

    // CS abort after 5 bits discards the partial byte
    do_reset();
    send_partial(8'hFF, 5);
    send_one(8'h3C);
    check("abort_count", we_count, 1);
    check("abort_addr", 32'(last_addr), 0);
    check("abort_data", 32'(last_data), 32'h3C);

    // Full frame in two transactions
    do_reset();
    for (int t = 0; t < 2; t++) begin
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(8'(t * 8 + i));
      send_txn(q);
    end
    check("frame_count", we_count, 16);
    check("frame_last_addr", 32'(last_addr), 15);
    check("frame_last_data", 32'(last_data), 15);
    check("frame_ready_lit", 32'(frame_ready), 1);
    check("frame_request_lit", 32'(request_flag), 0);

    // Overrun, then ack
    send_one(8'h77);
    check("ovr_no_write", we_count, 16);
    check("ovr_flag_lit", 32'(overrun), 1);
    pulse_ack();
    send_one(8'h11);
    check("ack_addr", 32'(last_addr), 0);
    check("ack_data", 32'(last_data), 32'h11);
    check("ack_overrun_kept", 32'(overrun), 1);

    // Reset mid-byte, mid-frame
    do_reset();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    send_txn(q);
    settled = 0;
    SPI_CS = 1'b0;
    wait_clks(half);
    send_bits(8'hC3, 4, 0);
    do_reset();
    send_one(8'h5A);
    check("rstmid_count", we_count, 1);
    check("rstmid_addr", 32'(last_addr), 0);
    check("rstmid_data", 32'(last_data), 32'h5A);

    // Byte completes in the ack cycle
    do_reset();
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    send_txn(q);
    settled = 0;
    SPI_CS = 1'b0;
    wait_clks(half);
    send_bits(8'hE7, 8, 1);
    model_ovr  = 1;
    model_full = 0;
    SPI_CS = 1'b1;
    wait_clks(half);
    settle();
    check("coll_no_write", we_count, 16);
    check("coll_overrun", 32'(overrun), 1);
    check("coll_ready", 32'(frame_ready), 0);
    send_one(8'h42);
    check("coll_next_addr", 32'(last_addr), 0);
    check("coll_next_data", 32'(last_data), 32'h42);

    // Randomized traffic
    do_reset();
    sent = 0;
    while (sent < 200) begin
      int unsigned r;
      half = $urandom_range(4, 7);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_partial(8'($urandom), $urandom_range(1, 7));
      end else if (r == 1 || (model_full && r < 5)) begin
        pulse_ack();
      end else begin
        int unsigned n;
        n = $urandom_range(1, 12);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        send_txn(q);
        sent += n;
      end
    end

    wait_clks(10);
    check("final_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
